// File: rtl/spm_pkg.sv
// spm_pkg: shared state encoding, default width and signed reference product for the serial-parallel multiplier.
package spm_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} spm_state_e;
   localparam int SPM_DEFAULT_WIDTH = 32;
   function automatic logic signed [63:0] spm_ref_mul(input logic signed [31:0] x, input logic signed [31:0] y);
      return 64'(x) * 64'(y);
   endfunction
endpackage

// File: rtl/spm_mult_seq_if.sv
// spm_mult_seq_if: operand/product valid-ready handshakes plus busy status.
interface spm_mult_seq_if #(parameter int WIDTH = 32);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_x;
   logic [WIDTH-1:0]   in_y;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] out_p;
   logic               busy;
   modport master (output in_valid, in_x, in_y, out_ready, input in_ready, out_valid, out_p, busy);
   modport slave (input in_valid, in_x, in_y, out_ready, output in_ready, out_valid, out_p, busy);
endinterface

// File: rtl/spm_csa_cell.sv
// spm_csa_cell: one carry-save slice; it registers the partial sum arriving from the slice above,
// and pp_neg turns the slice into a serial two's-complement negator for the sign-weighted top bit.
module spm_csa_cell (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic x,
   input  logic y,
   input  logic sum_in,
   input  logic pp_neg,
   output logic sum_out
);
   logic s_q, c_q, a;
   assign a = (x & y) ^ pp_neg;
   assign sum_out = a ^ s_q ^ c_q;
   // Negation is ~pp plus one, so the carry is preloaded with pp_neg on clear.
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         s_q <= 1'b0;
         c_q <= 1'b0;
      end else if (clr) begin
         s_q <= 1'b0;
         c_q <= pp_neg;
      end else begin
         s_q <= sum_in;
         c_q <= (a & s_q) | (c_q & (a ^ s_q));
      end
endmodule

// File: rtl/spm_mult_seq.sv
// spm_mult_seq: handshake wrapper that streams y LSB-first through a WIDTH-slice carry-save chain
// and collects the 2*WIDTH-bit signed product serially from slice 0.
module spm_mult_seq import spm_pkg::*; #(
   parameter int WIDTH = SPM_DEFAULT_WIDTH
) (
   input logic clk,
   input logic rst,
   spm_mult_seq_if.slave bus
);
   localparam int PW = 2 * WIDTH;
   localparam int CNT_W = $clog2(PW) + 1;
   spm_state_e       state;
   logic [WIDTH-1:0] x_q, sums, sum_in;
   logic [PW-1:0]    y_sh, prod_nxt;
   logic [PW-2:0]    prod_sh;
   logic [CNT_W-1:0] cnt;
   logic             accept;
   assign accept = state == IDLE && bus.in_valid && bus.in_ready;
   assign sum_in = {1'b0, sums[WIDTH-1:1]};
   assign prod_nxt = {sums[0], prod_sh};
   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      spm_csa_cell u_cell (
         .clk(clk), .rst(rst), .clr(accept), .x(x_q[i]), .y(y_sh[0]),
         .sum_in(sum_in[i]), .pp_neg(1'(i == WIDTH - 1)), .sum_out(sums[i])
      );
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= IDLE;
         bus.in_ready <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_p <= '0;
         bus.busy <= 1'b0;
         cnt <= '0;
         x_q <= '0;
         y_sh <= '0;
         prod_sh <= '0;
      end else begin
         case (state)
            IDLE: begin
               bus.in_ready <= !accept;
               if (accept) begin
                  x_q <= bus.in_x;
                  y_sh <= {{WIDTH{bus.in_y[WIDTH-1]}}, bus.in_y};
                  prod_sh <= '0;
                  cnt <= '0;
                  bus.busy <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               y_sh <= {y_sh[PW-1], y_sh[PW-1:1]};
               prod_sh <= prod_nxt[PW-1:1];
               cnt <= cnt + 1'b1;
               if (cnt == CNT_W'(PW - 1)) begin
                  bus.out_p <= prod_nxt;
                  bus.out_valid <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: if (bus.out_ready) begin
               bus.out_valid <= 1'b0;
               bus.busy <= 1'b0;
               bus.in_ready <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_spm_mult_seq.sv
// tb_spm_mult_seq: directed and random checks of the serial-parallel multiplier at WIDTH=8 and WIDTH=32.
module tb_spm_mult_seq;
   import spm_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   spm_mult_seq_if #(.WIDTH(8))  b8 ();
   spm_mult_seq_if #(.WIDTH(32)) b32 ();
   spm_mult_seq #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(b8));
   spm_mult_seq #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .bus(b32));
   int tests = 0;
   int fails = 0;
   logic [15:0] p8;
   logic [63:0] p32, e;
   logic [7:0]  rx, ry;
   logic [31:0] wx, wy;
   logic signed [7:0]  sx, sy;
   logic signed [31:0] lx, ly;
   int lat, n;
   bit ok;
   logic [7:0]  xs [5] = '{8'hFD, 8'h80, 8'h80, 8'h00, 8'h7F};
   logic [7:0]  ys [5] = '{8'h05, 8'h80, 8'h7F, 8'hFF, 8'h7F};
   logic [15:0] ps [5] = '{16'hFFF1, 16'h4000, 16'hC080, 16'h0000, 16'h3F01};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // One full transaction; lat counts clock edges from the accept edge (inclusive) to the edge raising out_valid.
   task automatic run8(input logic [7:0] x, input logic [7:0] y, input int hold, input bit keep,
                       output logic [15:0] p, output int l, output bit side_ok);
      int k = 0;
      side_ok = 1;
      b8.out_ready = (hold == 0);
      while (!b8.in_ready && k < 300) begin tick(); k++; end
      b8.in_valid = 1'b1;
      b8.in_x = x;
      b8.in_y = y;
      tick();
      l = 1;
      b8.in_valid = keep;
      b8.in_x = keep ? 8'd1 : 8'($urandom);
      b8.in_y = keep ? 8'd1 : 8'($urandom);
      while (!b8.out_valid && l < 300) begin
         if (b8.in_ready !== 1'b0 || b8.busy !== 1'b1) side_ok = 0;
         tick();
         l++;
      end
      p = b8.out_p;
      for (int i = 0; i < hold; i++) begin
         tick();
         if (b8.out_valid !== 1'b1 || b8.out_p !== p || b8.in_ready !== 1'b0) side_ok = 0;
      end
      b8.out_ready = 1'b1;
      tick();
      b8.out_ready = 1'b0;
      b8.in_valid = 1'b0;
      if (b8.out_valid !== 1'b0 || b8.in_ready !== 1'b1 || b8.busy !== 1'b0) side_ok = 0;
   endtask

   task automatic run32(input logic [31:0] x, input logic [31:0] y, input int hold,
                        output logic [63:0] p, output int l);
      int k = 0;
      b32.out_ready = (hold == 0);
      while (!b32.in_ready && k < 300) begin tick(); k++; end
      b32.in_valid = 1'b1;
      b32.in_x = x;
      b32.in_y = y;
      tick();
      l = 1;
      b32.in_valid = 1'($urandom);
      b32.in_x = $urandom;
      b32.in_y = $urandom;
      while (!b32.out_valid && l < 300) begin tick(); l++; end
      p = b32.out_p;
      repeat (hold) tick();
      b32.out_ready = 1'b1;
      tick();
      b32.out_ready = 1'b0;
      b32.in_valid = 1'b0;
   endtask

   initial begin
      b8.in_valid = 0; b8.out_ready = 0; b8.in_x = 0; b8.in_y = 0;
      b32.in_valid = 0; b32.out_ready = 0; b32.in_x = 0; b32.in_y = 0;
      #2 rst = 1'b0;
      #10;
      chk("rst_in_ready", b8.in_ready, 0);
      chk("rst_out_valid", b8.out_valid, 0);
      chk("rst_busy", b8.busy, 0);
      chk("rst_out_p", b8.out_p, 0);
      chk("rst_out_valid32", b32.out_valid, 0);
      @(negedge clk) rst = 1'b1;
      tick();
      chk("ready_after_rst", b8.in_ready, 1);
      chk("ready_after_rst32", b32.in_ready, 1);

      run8(8'd3, 8'd5, 0, 0, p8, lat, ok);
      chk("basic_lat", 64'(lat), 17);
      chk("basic_p", p8, 16'h000F);
      chk("basic_side", ok, 1);

      for (int i = 0; i < 5; i++) begin
         run8(xs[i], ys[i], 0, 1, p8, lat, ok);
         chk($sformatf("b2b_p%0d", i), p8, ps[i]);
         chk($sformatf("b2b_side%0d", i), ok, 1);
      end

      run8(8'd7, 8'hF7, 10, 0, p8, lat, ok);
      chk("bp_p", p8, 16'hFFC1);
      chk("bp_side", ok, 1);

      run8(8'd2, 8'd3, 0, 1, p8, lat, ok);
      chk("ign_p", p8, 16'h0006);
      run8(8'd1, 8'd1, 0, 0, p8, lat, ok);
      chk("ign_next_p", p8, 16'h0001);

      b8.in_valid = 1'b1; b8.in_x = 8'hFB; b8.in_y = 8'd6;
      tick();
      b8.in_valid = 1'b0;
      repeat (5) tick();
      rst = 1'b0;
      #1;
      chk("rstrun_out_valid", b8.out_valid, 0);
      chk("rstrun_busy", b8.busy, 0);
      chk("rstrun_in_ready", b8.in_ready, 0);
      @(negedge clk) rst = 1'b1;
      run8(8'd4, 8'd4, 0, 0, p8, lat, ok);
      chk("after_rst_p", p8, 16'h0010);
      chk("after_rst_lat", 64'(lat), 17);

      b8.in_valid = 1'b1; b8.in_x = 8'd2; b8.in_y = 8'd2;
      tick();
      b8.in_valid = 1'b0;
      n = 0;
      while (!b8.out_valid && n < 40) begin tick(); n++; end
      chk("done_reached", b8.out_valid, 1);
      rst = 1'b0;
      #1;
      chk("rstdone_out_valid", b8.out_valid, 0);
      chk("rstdone_out_p", b8.out_p, 0);
      @(negedge clk) rst = 1'b1;

      for (int i = 0; i < 800; i++) begin
         rx = 8'($urandom);
         ry = 8'($urandom);
         run8(rx, ry, $urandom_range(0, 3), 1'($urandom), p8, lat, ok);
         sx = rx; sy = ry; lx = sx; ly = sy;
         e = spm_ref_mul(lx, ly);
         chk($sformatf("rnd8 %0d*%0d", sx, sy), p8, e[15:0]);
      end

      run32(32'h8000_0000, 32'h8000_0000, 0, p32, lat);
      chk("w32_minmin", p32, 64'h4000_0000_0000_0000);
      chk("w32_lat", 64'(lat), 65);
      for (int i = 0; i < 300; i++) begin
         wx = $urandom;
         wy = i % 16 == 0 ? 32'h7FFF_FFFF : $urandom;
         run32(wx, wy, $urandom_range(0, 3), p32, lat);
         chk($sformatf("rnd32 %0h*%0h", wx, wy), p32, spm_ref_mul(wx, wy));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
